// File: rtl/afifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion and pointer sizing.
package afifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Pointer carries one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits above the real pointer width are zero, so the fixed width is harmless.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_gray_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module gray_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First stage may go metastable; second stage is the only consumer-visible copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afifo_ctl.sv
// Dual-clock pixel FIFO between video input (wr_clk) and scaler (rd_clk) domains.
// Gray pointers cross via gray_sync; counts and flags are registered per domain.
module afifo_ctl
  import afifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 2**ADDR_W - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              wr_clk,
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int unsigned PW = ptr_w(ADDR_W);
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write domain
  logic [PW-1:0] wr_ptr, wr_gray, wr_ptr_next, wr_gray_next;
  logic [PW-1:0] rsync, rsync_bin, wr_count_next;
  logic          wr_accept;

  // read domain
  logic [PW-1:0] rd_ptr, rd_gray, rd_ptr_next, rd_gray_next;
  logic [PW-1:0] wsync, wsync_bin, rd_count_next;
  logic          ram_empty, ram_read;

  gray_sync #(.W(PW)) u_rd2wr (.clk(wr_clk), .rst(rst), .d(rd_gray), .q(rsync));
  gray_sync #(.W(PW)) u_wr2rd (.clk(rd_clk), .rst(rst), .d(wr_gray), .q(wsync));

  // Next write pointer and occupancy, so flags reflect the write on its own edge.
  always_comb begin
    wr_accept     = wr_en && !full;
    wr_ptr_next   = wr_ptr + PW'(wr_accept);
    wr_gray_next  = PW'(bin2gray(GRAY_MAX_W'(wr_ptr_next)));
    rsync_bin     = PW'(gray2bin(GRAY_MAX_W'(rsync)));
    wr_count_next = wr_ptr_next - rsync_bin;
  end

  // Write-side pointer, flag and count registers.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      wr_gray     <= wr_gray_next;
      full        <= (wr_gray_next == {~rsync[PW-1:PW-2], rsync[PW-3:0]});
      almost_full <= (wr_count_next >= AFULL_V);
      wr_count    <= wr_count_next;
      overflow    <= wr_en && full;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge wr_clk) begin
    if (wr_accept) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  // FWFT refills the output register whenever it is empty or being popped.
  always_comb begin
    if (MODE == RD_FWFT) ram_read = !ram_empty && (!valid || rd_en);
    else                 ram_read = rd_en && !ram_empty;
    rd_ptr_next   = rd_ptr + PW'(ram_read);
    rd_gray_next  = PW'(bin2gray(GRAY_MAX_W'(rd_ptr_next)));
    wsync_bin     = PW'(gray2bin(GRAY_MAX_W'(wsync)));
    rd_count_next = wsync_bin - rd_ptr_next;
  end

  assign empty = (MODE == RD_FWFT) ? !valid : ram_empty;

  // Read-side pointer, flags, counts and registered RAM output.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      rd_gray      <= '0;
      ram_empty    <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
      valid        <= 1'b0;
      dout         <= '0;
    end else begin
      rd_ptr       <= rd_ptr_next;
      rd_gray      <= rd_gray_next;
      ram_empty    <= (rd_gray_next == wsync);
      rd_count     <= rd_count_next;
      almost_empty <= (rd_count_next <= AEMPTY_V);
      if (MODE == RD_FWFT) begin
        underflow <= rd_en && !valid;
        if (ram_read) begin
          dout  <= mem[rd_ptr[ADDR_W-1:0]];
          valid <= 1'b1;
        end else if (rd_en) begin
          valid <= 1'b0;
        end
      end else begin
        underflow <= rd_en && ram_empty;
        valid     <= ram_read;
        if (ram_read) dout <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_afifo_ctl.sv
// Bench for afifo_ctl: one standard-read and one FWFT instance on shared clocks.
`timescale 1ns/1ps
module tb_afifo_ctl;

  localparam int DW = 16;
  localparam int AW = 4;

  real wr_half = 5.0;
  real rd_half = 13.5;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic rst    = 1'b1;
  logic [DW-1:0] din = '0;
  logic s_wr_en = 1'b0, f_wr_en = 1'b0;
  logic s_rd_en = 1'b0, f_rd_en = 1'b0;

  logic          s_full, s_almost_full, s_overflow, s_valid, s_empty, s_almost_empty, s_underflow;
  logic [AW:0]   s_wr_count, s_rd_count;
  logic [DW-1:0] s_dout;
  logic          f_full, f_almost_full, f_overflow, f_valid, f_empty, f_almost_empty, f_underflow;
  logic [AW:0]   f_wr_count, f_rd_count;
  logic [DW-1:0] f_dout;

  int n_checks = 0;
  int n_errors = 0;
  int wr_edges = 0;
  int rd_edges = 0;
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];

  afifo_ctl #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_std (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
    .wr_en(s_wr_en), .din(din), .full(s_full), .almost_full(s_almost_full),
    .wr_count(s_wr_count), .overflow(s_overflow),
    .rd_en(s_rd_en), .dout(s_dout), .valid(s_valid), .empty(s_empty),
    .almost_empty(s_almost_empty), .rd_count(s_rd_count), .underflow(s_underflow)
  );

  afifo_ctl #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_fwft (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
    .wr_en(f_wr_en), .din(din), .full(f_full), .almost_full(f_almost_full),
    .wr_count(f_wr_count), .overflow(f_overflow),
    .rd_en(f_rd_en), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .almost_empty(f_almost_empty), .rd_count(f_rd_count), .underflow(f_underflow)
  );

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;
  always @(posedge wr_clk) wr_edges++;
  always @(posedge rd_clk) rd_edges++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic rd_tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic run_phase(input int n, input real wh, input real rh);
    int ovf = 0;
    int unf = 0;
    int sent = 0;
    int got_s = 0;
    int got_f = 0;
    wr_half = wh;
    rd_half = rh;
    fork
      begin
        int cyc = 0;
        while (sent < n && cyc < n * 12 + 1000) begin
          wr_tick();
          cyc++;
          if (s_overflow || f_overflow) ovf++;
          if (!s_full && !f_full && $urandom_range(3) != 0) begin
            din = DW'($urandom);
            s_wr_en = 1'b1;
            f_wr_en = 1'b1;
            q_s.push_back(din);
            q_f.push_back(din);
            sent++;
          end else begin
            s_wr_en = 1'b0;
            f_wr_en = 1'b0;
          end
        end
        wr_tick();
        s_wr_en = 1'b0;
        f_wr_en = 1'b0;
      end
      begin
        int cyc = 0;
        logic [DW-1:0] exp;
        while (got_s < n && cyc < n * 12 + 1000) begin
          rd_tick();
          cyc++;
          if (s_underflow) unf++;
          if (s_valid) begin
            exp = (q_s.size() != 0) ? q_s.pop_front() : 'x;
            check("std_sb_data", 32'(s_dout), 32'(exp));
            got_s++;
          end
          s_rd_en = !s_empty && ($urandom_range(3) != 0);
        end
        s_rd_en = 1'b0;
      end
      begin
        int cyc = 0;
        logic [DW-1:0] exp;
        while (got_f < n && cyc < n * 12 + 1000) begin
          rd_tick();
          cyc++;
          if (f_underflow) unf++;
          if (f_valid && $urandom_range(3) != 0) begin
            exp = (q_f.size() != 0) ? q_f.pop_front() : 'x;
            check("fwft_sb_data", 32'(f_dout), 32'(exp));
            got_f++;
            f_rd_en = 1'b1;
          end else begin
            f_rd_en = 1'b0;
          end
        end
        rd_tick();
        f_rd_en = 1'b0;
      end
    join
    check("rand_sent", sent, n);
    check("rand_std_words", got_s, n);
    check("rand_fwft_words", got_f, n);
    check("rand_overflow", ovf, 0);
    check("rand_underflow", unf, 0);
    check("rand_std_sb_left", q_s.size(), 0);
    check("rand_fwft_sb_left", q_f.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    int s_lat;
    int f_lat;

    // reset values while rst is held
    rst = 1'b1;
    #100;
    check("rst_full", 32'(s_full), 0);
    check("rst_afull", 32'(s_almost_full), 0);
    check("rst_wr_count", 32'(s_wr_count), 0);
    check("rst_overflow", 32'(s_overflow), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_aempty", 32'(s_almost_empty), 1);
    check("rst_rd_count", 32'(s_rd_count), 0);
    check("rst_valid", 32'(s_valid), 0);
    check("rst_dout", 32'(s_dout), 0);
    check("rst_underflow", 32'(s_underflow), 0);
    check("rst_f_full", 32'(f_full), 0);
    check("rst_f_afull", 32'(f_almost_full), 0);
    check("rst_f_wr_count", 32'(f_wr_count), 0);
    check("rst_f_empty", 32'(f_empty), 1);
    check("rst_f_aempty", 32'(f_almost_empty), 1);
    check("rst_f_rd_count", 32'(f_rd_count), 0);
    check("rst_f_valid", 32'(f_valid), 0);
    wr_tick();
    rst = 1'b0;
    repeat (3) rd_tick();
    wr_tick();

    // fill: 16 writes to both, 17th only to the standard instance
    for (int i = 0; i < 17; i++) begin
      s_wr_en = 1'b1;
      f_wr_en = (i < 16);
      din = DW'(i);
      wr_tick();
      if (i == 10) check("afull_below_th", 32'(s_almost_full), 0);
      if (i == 11) check("afull_at_th", 32'(s_almost_full), 1);
      if (i == 14) check("not_full_15", 32'(s_full), 0);
      if (i == 15) begin
        check("full_16", 32'(s_full), 1);
        check("wr_count_16", 32'(s_wr_count), 16);
      end
    end
    s_wr_en = 1'b0;
    f_wr_en = 1'b0;
    check("overflow_pulse", 32'(s_overflow), 1);
    check("wr_count_hold", 32'(s_wr_count), 16);
    wr_tick();
    check("overflow_clear", 32'(s_overflow), 0);
    repeat (6) rd_tick();
    check("rd_count_16", 32'(s_rd_count), 16);
    check("empty_low", 32'(s_empty), 0);
    check("aempty_low", 32'(s_almost_empty), 0);
    check("fwft_head_valid", 32'(f_valid), 1);
    check("fwft_head_dout", 32'(f_dout), 0);
    check("fwft_rd_count", 32'(f_rd_count), 15);

    // one read from full, then time the full release in wr_clk edges
    s_rd_en = 1'b1;
    @(posedge rd_clk);
    snap = wr_edges;
    #1;
    s_rd_en = 1'b0;
    check("rd0_valid", 32'(s_valid), 1);
    check("rd0_dout", 32'(s_dout), 0);
    s_lat = 0;
    for (int k = 0; k < 8 && s_lat == 0; k++) begin
      wr_tick();
      if (!s_full) s_lat = wr_edges - snap;
    end
    check("full_release_lat", s_lat, 3);
    check("wr_count_15", 32'(s_wr_count), 15);

    // drain the rest; value 16 must never show up
    s_rd_en = 1'b1;
    for (int k = 1; k < 16; k++) begin
      rd_tick();
      check("std_valid", 32'(s_valid), 1);
      check("std_dout", 32'(s_dout), k);
      if (k == 12) begin
        check("rd_count_3", 32'(s_rd_count), 3);
        check("aempty_at_3", 32'(s_almost_empty), 0);
      end
      if (k == 13) begin
        check("rd_count_2", 32'(s_rd_count), 2);
        check("aempty_at_2", 32'(s_almost_empty), 1);
      end
    end
    s_rd_en = 1'b0;
    check("empty_after_drain", 32'(s_empty), 1);

    // FWFT drain with back-to-back acknowledges
    for (int k = 0; k < 16; k++) begin
      check("fwft_valid", 32'(f_valid), 1);
      check("fwft_dout", 32'(f_dout), k);
      f_rd_en = 1'b1;
      rd_tick();
    end
    f_rd_en = 1'b0;
    check("fwft_drained_valid", 32'(f_valid), 0);
    check("fwft_drained_empty", 32'(f_empty), 1);

    // reads on empty
    s_rd_en = 1'b1;
    f_rd_en = 1'b1;
    rd_tick();
    s_rd_en = 1'b0;
    f_rd_en = 1'b0;
    check("underflow_pulse", 32'(s_underflow), 1);
    check("f_underflow_pulse", 32'(f_underflow), 1);
    check("underflow_valid", 32'(s_valid), 0);
    check("underflow_rd_count", 32'(s_rd_count), 0);
    rd_tick();
    check("underflow_clear", 32'(s_underflow), 0);
    check("f_underflow_clear", 32'(f_underflow), 0);

    // single word into empty FIFOs: latency in rd_clk edges
    s_wr_en = 1'b1;
    f_wr_en = 1'b1;
    din = 16'hA5A5;
    @(posedge wr_clk);
    snap = rd_edges;
    #1;
    s_wr_en = 1'b0;
    f_wr_en = 1'b0;
    s_lat = 0;
    f_lat = 0;
    for (int k = 0; k < 10 && (s_lat == 0 || f_lat == 0); k++) begin
      rd_tick();
      if (!s_empty && s_lat == 0) s_lat = rd_edges - snap;
      if (f_valid && f_lat == 0) f_lat = rd_edges - snap;
    end
    check("empty_release_lat", s_lat, 3);
    check("fwft_valid_lat", f_lat, 4);
    check("fwft_single_dout", 32'(f_dout), 32'h0000A5A5);
    s_rd_en = 1'b1;
    rd_tick();
    s_rd_en = 1'b0;
    check("single_valid", 32'(s_valid), 1);
    check("single_dout", 32'(s_dout), 32'h0000A5A5);
    check("single_no_underflow", 32'(s_underflow), 0);
    rd_tick();
    check("single_valid_drop", 32'(s_valid), 0);
    check("single_dout_hold", 32'(s_dout), 32'h0000A5A5);
    check("single_empty", 32'(s_empty), 1);
    f_rd_en = 1'b1;
    rd_tick();
    f_rd_en = 1'b0;
    check("fwft_pop_valid", 32'(f_valid), 0);
    check("fwft_pop_underflow", 32'(f_underflow), 0);
    check("fwft_pop_empty", 32'(f_empty), 1);

    // reset with 7 words stored
    for (int i = 0; i < 7; i++) begin
      s_wr_en = 1'b1;
      f_wr_en = 1'b1;
      din = DW'(100 + i);
      wr_tick();
    end
    s_wr_en = 1'b0;
    f_wr_en = 1'b0;
    repeat (6) rd_tick();
    check("pre_rst_rd_count", 32'(s_rd_count), 7);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_count", 32'(s_wr_count), 0);
    check("mid_rst_rd_count", 32'(s_rd_count), 0);
    check("mid_rst_empty", 32'(s_empty), 1);
    check("mid_rst_aempty", 32'(s_almost_empty), 1);
    check("mid_rst_dout", 32'(s_dout), 0);
    check("mid_rst_f_valid", 32'(f_valid), 0);
    check("mid_rst_f_dout", 32'(f_dout), 0);
    check("mid_rst_f_empty", 32'(f_empty), 1);
    check("mid_rst_f_wr_count", 32'(f_wr_count), 0);
    #100;
    wr_tick();
    rst = 1'b0;
    repeat (3) rd_tick();

    // random traffic at three clock ratios, 10,000 words total
    run_phase(3334, 5.0, 15.0);
    run_phase(3333, 15.0, 5.0);
    run_phase(3333, 5.0, 5.0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
